// File: rtl/multi_drv_resolver_pkg.sv
// Shared constants and helpers for the multi-driver resolver.
// Mode encodings and packed bus sizing.
package multi_drv_resolver_pkg;

    localparam int MODE_WIRE = 0;
    localparam int MODE_WAND = 1;
    localparam int MODE_WOR  = 2;

    function automatic int bus_w(input int nch, input int w);
        return nch * w;
    endfunction

endpackage

// File: rtl/multi_drv_resolver_bit.sv
// Single-bit resolution of NCH tri-state drivers.
// Purely combinational; MODE selects wire, wand or wor semantics.
module drv_bit_resolve
    import multi_drv_resolver_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int MODE = MODE_WIRE
) (
    input  logic [NCH-1:0] en,
    input  logic [NCH-1:0] d,
    output logic           r,
    output logic           z,
    output logic           x
);

    logic any_en;
    logic all_one;
    logic any_one;

    assign any_en  = |en;
    assign all_one = &(d | ~en);
    assign any_one = |(d & en);

    always_comb begin
        r = 1'b0;
        z = ~any_en;
        x = 1'b0;
        if (any_en) begin
            if (MODE == MODE_WOR) begin
                r = any_one;
            end else if (MODE == MODE_WAND) begin
                r = all_one;
            end else begin
                // Enabled drivers agree only if all are 1 or none is 1
                r = all_one;
                x = any_one & ~all_one;
            end
        end
    end

endmodule

// File: rtl/multi_drv_resolver.sv
// Resolves NCH packed drivers into one W-bit value with z/x masks,
// a one-stage valid/ready output register and conflict statistics.
module multi_drv_resolver
    import multi_drv_resolver_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_WIRE,
    parameter int CNTW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NCH-1:0]           drv_en,
    input  logic [bus_w(NCH,W)-1:0]  drv_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             res_data,
    output logic [W-1:0]             zmask,
    output logic [W-1:0]             xmask,
    output logic [CNTW-1:0]          conflict_cnt,
    output logic                     conflict_sticky,
    input  logic                     clr
);

    logic [W-1:0] res_n;
    logic [W-1:0] z_n;
    logic [W-1:0] x_n;
    logic         accept;
    logic         hit;

    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [NCH-1:0] col;
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            assign col[c] = drv_data[c*W+b];
        end
        drv_bit_resolve #(
            .NCH  (NCH),
            .MODE (MODE)
        ) u_bit (
            .en (drv_en),
            .d  (col),
            .r  (res_n[b]),
            .z  (z_n[b]),
            .x  (x_n[b])
        );
    end

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign hit      = accept & (|x_n) & (MODE == MODE_WIRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res_data  <= '0;
            zmask     <= '0;
            xmask     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            res_data  <= res_n;
            zmask     <= z_n;
            xmask     <= x_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear takes priority over a coincident conflict
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            conflict_cnt    <= '0;
            conflict_sticky <= 1'b0;
        end else if (hit) begin
            conflict_sticky <= 1'b1;
            if (conflict_cnt != {CNTW{1'b1}}) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_drv_resolver.sv
// Bench: four resolver instances (wire, wand, wor, wire with 2-bit counter)
// share stimulus and are checked against a bit-counting behavioural model.
module tb_multi_drv_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        clr;
    logic [3:0]  drv_en;
    logic [31:0] drv_data;

    logic        ir   [4];
    logic        ov   [4];
    logic [7:0]  rd   [4];
    logic [7:0]  zm   [4];
    logic [7:0]  xm   [4];
    logic [15:0] cn   [4];
    logic        st   [4];
    logic [15:0] cn0, cn1, cn2;
    logic [1:0]  cn3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_drv_resolver #(.NCH(4), .W(8), .MODE(0), .CNTW(16)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .drv_en(drv_en), .drv_data(drv_data), .out_valid(ov[0]),
        .out_ready(out_ready), .res_data(rd[0]), .zmask(zm[0]),
        .xmask(xm[0]), .conflict_cnt(cn0), .conflict_sticky(st[0]),
        .clr(clr));
    multi_drv_resolver #(.NCH(4), .W(8), .MODE(1), .CNTW(16)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .drv_en(drv_en), .drv_data(drv_data), .out_valid(ov[1]),
        .out_ready(out_ready), .res_data(rd[1]), .zmask(zm[1]),
        .xmask(xm[1]), .conflict_cnt(cn1), .conflict_sticky(st[1]),
        .clr(clr));
    multi_drv_resolver #(.NCH(4), .W(8), .MODE(2), .CNTW(16)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .drv_en(drv_en), .drv_data(drv_data), .out_valid(ov[2]),
        .out_ready(out_ready), .res_data(rd[2]), .zmask(zm[2]),
        .xmask(xm[2]), .conflict_cnt(cn2), .conflict_sticky(st[2]),
        .clr(clr));
    multi_drv_resolver #(.NCH(4), .W(8), .MODE(0), .CNTW(2)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
        .drv_en(drv_en), .drv_data(drv_data), .out_valid(ov[3]),
        .out_ready(out_ready), .res_data(rd[3]), .zmask(zm[3]),
        .xmask(xm[3]), .conflict_cnt(cn3), .conflict_sticky(st[3]),
        .clr(clr));

    assign cn[0] = cn0;
    assign cn[1] = cn1;
    assign cn[2] = cn2;
    assign cn[3] = {14'd0, cn3};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: count enabled ones and zeros per bit
    function automatic void resolve(input int md, input logic [3:0] en,
                                    input logic [31:0] dd,
                                    output logic [7:0] r,
                                    output logic [7:0] z,
                                    output logic [7:0] x);
        int n1;
        int n0;
        r = '0;
        z = '0;
        x = '0;
        for (int b = 0; b < 8; b++) begin
            n1 = 0;
            n0 = 0;
            for (int c = 0; c < 4; c++) begin
                if (en[c]) begin
                    if (dd[c*8+b]) n1++;
                    else n0++;
                end
            end
            if (n1 + n0 == 0) z[b] = 1'b1;
            else if (md == 1) r[b] = (n0 == 0);
            else if (md == 2) r[b] = (n1 > 0);
            else if (n1 > 0 && n0 > 0) x[b] = 1'b1;
            else r[b] = (n1 > 0);
        end
    endfunction

    int          mode_of [4] = '{0, 1, 2, 0};
    int          cmax    [4] = '{65535, 65535, 65535, 3};
    logic        mv      [4];
    logic [7:0]  mr      [4];
    logic [7:0]  mz      [4];
    logic [7:0]  mx      [4];
    int          mc      [4];
    logic        ms      [4];
    logic        model_ok = 1'b0;

    always @(posedge clk) begin
        logic [7:0] r, z, x;
        logic acc;
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                mv[d] = 1'b0;
                mr[d] = '0;
                mz[d] = '0;
                mx[d] = '0;
                mc[d] = 0;
                ms[d] = 1'b0;
            end else if (model_ok) begin
                acc = in_valid && (!mv[d] || out_ready);
                resolve(mode_of[d], drv_en, drv_data, r, z, x);
                if (clr) begin
                    mc[d] = 0;
                    ms[d] = 1'b0;
                end else if (acc && x != 0) begin
                    ms[d] = 1'b1;
                    if (mc[d] < cmax[d]) mc[d]++;
                end
                if (acc) begin
                    mv[d] = 1'b1;
                    mr[d] = r;
                    mz[d] = z;
                    mx[d] = x;
                end else if (out_ready) begin
                    mv[d] = 1'b0;
                end
            end
        end
        if (rst) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("m%0d_in_ready", d), 32'(ir[d]),
                    32'(!mv[d] || out_ready));
                chk($sformatf("m%0d_out_valid", d), 32'(ov[d]), 32'(mv[d]));
                chk($sformatf("m%0d_res", d), 32'(rd[d]), 32'(mr[d]));
                chk($sformatf("m%0d_zmask", d), 32'(zm[d]), 32'(mz[d]));
                chk($sformatf("m%0d_xmask", d), 32'(xm[d]), 32'(mx[d]));
                chk($sformatf("m%0d_cnt", d), 32'(cn[d]), 32'(mc[d]));
                chk($sformatf("m%0d_sticky", d), 32'(st[d]), 32'(ms[d]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic snap(input logic [3:0] en, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d);
        in_valid = 1'b1;
        drv_en   = en;
        drv_data = {d, c, b, a};
    endtask

    initial begin
        logic [7:0] base;
        logic [7:0] v [4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        drv_en    = '0;
        drv_data  = '0;
        cyc();
        cyc();
        chk("rst_out_valid", 32'(ov[0]), 32'd0);
        chk("rst_cnt", 32'(cn[0]), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_in_ready", 32'(ir[0]), 32'd1);

        snap(4'b0011, 8'hA5, 8'hA5, 8'h00, 8'h00);
        cyc();
        chk("agree_res", 32'(rd[0]), 32'h A5);
        chk("agree_z", 32'(zm[0]), 32'h00);
        chk("agree_x", 32'(xm[0]), 32'h00);
        chk("agree_cnt", 32'(cn[0]), 32'd0);

        snap(4'b0011, 8'hF0, 8'hFF, 8'h00, 8'h00);
        cyc();
        chk("conf_x", 32'(xm[0]), 32'h0F);
        chk("conf_res", 32'(rd[0]), 32'hF0);
        chk("conf_cnt", 32'(cn[0]), 32'd1);
        chk("conf_sticky", 32'(st[0]), 32'd1);

        snap(4'b0000, 8'h12, 8'h34, 8'h56, 8'h78);
        cyc();
        chk("hiz_z", 32'(zm[0]), 32'hFF);
        chk("hiz_res", 32'(rd[0]), 32'h00);
        chk("hiz_x", 32'(xm[0]), 32'h00);

        snap(4'b1111, 8'hFF, 8'hF0, 8'h3C, 8'hFF);
        cyc();
        chk("wand_res", 32'(rd[1]), 32'h30);
        chk("wor_res", 32'(rd[2]), 32'hFF);
        chk("wand_cnt", 32'(cn[1]), 32'd0);

        out_ready = 1'b0;
        snap(4'b1111, 8'h0F, 8'h0F, 8'h0F, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", 32'(ir[1]), 32'd0);
            cyc();
            chk("stall_hold_res", 32'(rd[1]), 32'h30);
            chk("stall_valid", 32'(ov[1]), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(ir[1]), 32'd1);
        cyc();
        chk("next_snap_res", 32'(rd[1]), 32'h0F);

        in_valid = 1'b0;
        clr      = 1'b1;
        cyc();
        chk("clr_cnt3", 32'(cn[3]), 32'd0);
        chk("clr_sticky3", 32'(st[3]), 32'd0);
        clr = 1'b0;
        snap(4'b0011, 8'hF0, 8'hFF, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_cnt3", 32'(cn[3]), 32'd3);
        chk("nosat_cnt0", 32'(cn[0]), 32'd5);
        clr = 1'b1;
        cyc();
        chk("clr_win_cnt3", 32'(cn[3]), 32'd0);
        chk("clr_win_sticky3", 32'(st[3]), 32'd0);
        clr = 1'b0;

        out_ready = 1'b0;
        cyc();
        chk("hold_valid", 32'(ov[0]), 32'd1);
        rst = 1'b1;
        cyc();
        chk("rst_hold_valid", 32'(ov[0]), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc();

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(63) == 0);
            clr       = ($urandom_range(31) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            drv_en    = 4'($urandom);
            base      = 8'($urandom);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(1) == 0) v[c] = base;
                else v[c] = base ^ (8'd1 << $urandom_range(7));
            end
            if ($urandom_range(7) == 0) drv_data = $urandom;
            else drv_data = {v[3], v[2], v[1], v[0]};
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
